// File: rtl/dig_out_pkg.sv
// Shared constants and register-select encoding for the digital output port.
// The channel stride of 0x10 keeps the legacy three-channel addresses unchanged.
package dig_out_pkg;

   typedef enum logic [1:0] {
      REG_DATA  = 2'd0,
      REG_SET   = 2'd1,
      REG_CLR   = 2'd2,
      REG_PULSE = 2'd3
   } reg_sel_t;

   localparam logic [15:0] CH_STRIDE     = 16'h10;
   localparam int unsigned PULSE_LEN_LSB = 16;

endpackage

// File: rtl/dig_out_port_n_if.sv
// Bus-side signals of the digital output port, seen from the slave's point of view.
interface dig_out_port_n_if;

   logic [31:0] iADR;
   logic [31:0] iDAT;
   logic [31:0] oDAT;
   logic        iWE;
   logic        iSTB;
   logic        oACK;

   modport master (
      output iADR, iDAT, iWE, iSTB,
      input  oDAT, oACK
   );

   modport slave (
      input  iADR, iDAT, iWE, iSTB,
      output oDAT, oACK
   );

endinterface

// File: rtl/dig_out_port_n_chan.sv
// One output channel: output register, pulse mask and self-timed down-counter.
// Bus writes take priority over the channel's own pulse expiry.
module dig_out_chan
   import dig_out_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr,
   input  reg_sel_t         i_sel,
   input  logic [DW-1:0]    i_data,
   input  logic [CNT_W-1:0] i_len,
   output logic [DW-1:0]    o_out,
   output logic [DW-1:0]    o_mask,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_busy
);

   logic [DW-1:0]    r_out;
   logic [DW-1:0]    r_mask;
   logic [CNT_W-1:0] r_cnt;

   logic [DW-1:0]    w_out_nxt;
   logic [DW-1:0]    w_mask_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_expire;

   assign w_expire = (r_cnt == CNT_W'(1));

   always_comb begin
      w_out_nxt  = r_out;
      w_mask_nxt = r_mask;
      w_cnt_nxt  = r_cnt;

      if (r_cnt != '0) begin
         w_cnt_nxt = r_cnt - CNT_W'(1);
         if (w_expire) begin
            w_out_nxt  = r_out ^ r_mask;
            w_mask_nxt = '0;
         end
      end

      if (i_wr) begin
         unique case (i_sel)
            REG_DATA: begin
               w_out_nxt  = i_data;
               w_mask_nxt = '0;
               w_cnt_nxt  = '0;
            end
            REG_SET: begin
               w_out_nxt  = r_out | i_data;
               w_mask_nxt = '0;
               w_cnt_nxt  = '0;
            end
            REG_CLR: begin
               w_out_nxt  = r_out & ~i_data;
               w_mask_nxt = '0;
               w_cnt_nxt  = '0;
            end
            REG_PULSE: begin
               // Old mask is still applied to r_out, so one XOR both restores and re-arms.
               if (i_len != '0) begin
                  w_out_nxt  = r_out ^ r_mask ^ i_data;
                  w_mask_nxt = i_data;
                  w_cnt_nxt  = i_len;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_out  <= '0;
         r_mask <= '0;
         r_cnt  <= '0;
      end else begin
         r_out  <= w_out_nxt;
         r_mask <= w_mask_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign o_out  = r_out;
   assign o_mask = r_mask;
   assign o_cnt  = r_cnt;
   assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/dig_out_port_n.sv
// Parametrised digital output port: address decode, per-channel instances,
// read mux, single-cycle acknowledge and registered read data.
module dig_out_port_n
   import dig_out_pkg::*;
#(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned DW     = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   dig_out_port_n_if.slave      bus,
   output logic [NUM_CH*DW-1:0] oDOUT,
   output logic [NUM_CH-1:0]    oPULSE_BUSY
);

   logic [3:0]       w_ch;
   reg_sel_t         w_sel;
   logic             w_acc;
   logic [NUM_CH-1:0] w_wr;
   logic [31:0]      w_rd;
   logic             w_unused;

   logic [DW-1:0]    w_out  [NUM_CH];
   logic [DW-1:0]    w_mask [NUM_CH];
   logic [CNT_W-1:0] w_cnt  [NUM_CH];

   logic             r_ack;
   logic [31:0]      r_dat;

   assign w_ch     = bus.iADR[7:4];
   assign w_sel    = reg_sel_t'(bus.iADR[3:2]);
   assign w_acc    = bus.iSTB & ~r_ack;
   assign w_unused = ^{bus.iADR[31:8], bus.iADR[1:0], bus.iDAT};

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign w_wr[k] = w_acc & bus.iWE & (w_ch == 4'(k));

      dig_out_chan #(
         .DW    (DW),
         .CNT_W (CNT_W)
      ) u_chan (
         .i_clk  (iCLK),
         .i_rst  (iRST),
         .i_wr   (w_wr[k]),
         .i_sel  (w_sel),
         .i_data (bus.iDAT[DW-1:0]),
         .i_len  (bus.iDAT[PULSE_LEN_LSB +: CNT_W]),
         .o_out  (w_out[k]),
         .o_mask (w_mask[k]),
         .o_cnt  (w_cnt[k]),
         .o_busy (oPULSE_BUSY[k])
      );

      assign oDOUT[k*DW +: DW] = w_out[k];
   end

   // Channels at or above NUM_CH match no index and read as zero.
   always_comb begin
      w_rd = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (w_ch == 4'(k)) begin
            if (w_sel == REG_PULSE) begin
               w_rd[DW-1:0]                 = w_mask[k];
               w_rd[PULSE_LEN_LSB +: CNT_W] = w_cnt[k];
            end else begin
               w_rd[DW-1:0] = w_out[k];
            end
         end
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_acc;
         r_dat <= (w_acc & ~bus.iWE) ? w_rd : '0;
      end
   end

   assign bus.oACK = r_ack;
   assign bus.oDAT = r_dat;

endmodule

// File: tb/tb_dig_out_port_n.sv
// Bench for dig_out_port_n: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a time-based behavioural model.
module tb_dig_out_port_n;

   localparam int NUM_CH = 3;
   localparam int DW     = 8;
   localparam int CNT_W  = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NUM_CH*DW-1:0] dout;
   logic [NUM_CH-1:0]    busy;

   dig_out_port_n_if bus ();

   dig_out_port_n #(
      .NUM_CH (NUM_CH),
      .DW     (DW),
      .CNT_W  (CNT_W)
   ) dut (
      .iCLK        (clk),
      .iRST        (rst),
      .bus         (bus),
      .oDOUT       (dout),
      .oPULSE_BUSY (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each channel is a base value plus a mask that is visible while the
   // edge counter n is below the pulse end edge.
   int          n = 0;
   logic        m_ack = 1'b0;
   logic [31:0] m_rdat = '0;
   logic [DW-1:0] m_base [16];
   logic [DW-1:0] m_mask [16];
   int            m_end  [16];

   initial begin
      for (int i = 0; i < 16; i++) begin
         m_base[i] = '0;
         m_mask[i] = '0;
         m_end[i]  = 0;
      end
   end

   function automatic logic [DW-1:0] vis(input int ch, input int t);
      return m_base[ch] ^ ((t < m_end[ch]) ? m_mask[ch] : '0);
   endfunction

   always @(posedge clk or posedge rst) begin
      int            ch;
      int            len;
      logic [DW-1:0] d;
      logic [DW-1:0] cur;
      logic          acc;
      if (rst) begin
         n      = 0;
         m_ack  = 1'b0;
         m_rdat = '0;
         for (int i = 0; i < 16; i++) begin
            m_base[i] = '0;
            m_mask[i] = '0;
            m_end[i]  = 0;
         end
      end else begin
         n++;
         acc    = bus.iSTB && !m_ack;
         m_rdat = '0;
         if (acc) begin
            ch  = int'(bus.iADR[7:4]);
            d   = bus.iDAT[DW-1:0];
            len = int'(bus.iDAT[31:16]);
            if (ch < NUM_CH) begin
               cur = vis(ch, n - 1);
               if (!bus.iWE) begin
                  if (bus.iADR[3:2] == 2'd3) begin
                     if (n - 1 < m_end[ch])
                        m_rdat = (32'(m_end[ch] - (n - 1)) << 16) | 32'(m_mask[ch]);
                  end else begin
                     m_rdat = 32'(cur);
                  end
               end else begin
                  case (bus.iADR[3:2])
                     2'd0: begin m_base[ch] = d;         m_end[ch] = 0; end
                     2'd1: begin m_base[ch] = cur | d;   m_end[ch] = 0; end
                     2'd2: begin m_base[ch] = cur & ~d;  m_end[ch] = 0; end
                     default: begin
                        if (len != 0) begin
                           m_base[ch] = cur ^ ((n - 1 < m_end[ch]) ? m_mask[ch] : '0);
                           m_mask[ch] = d;
                           m_end[ch]  = n + len;
                        end
                     end
                  endcase
               end
            end
         end
         m_ack = acc;
      end
   end

   always @(negedge clk) begin
      logic [NUM_CH*DW-1:0] ed;
      logic [NUM_CH-1:0]    eb;
      for (int i = 0; i < NUM_CH; i++) begin
         ed[i*DW +: DW] = vis(i, n);
         eb[i]          = (n < m_end[i]);
      end
      check("model_dout", 32'(dout), 32'(ed));
      check("model_busy", 32'(busy), 32'(eb));
      check("model_ack",  32'(bus.oACK), 32'(m_ack));
      check("model_rdat", bus.oDAT, m_ack ? m_rdat : 32'h0);
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #2;
      bus.iADR = a; bus.iDAT = d; bus.iWE = 1'b1; bus.iSTB = 1'b1;
      @(posedge clk); #2;
      bus.iSTB = 1'b0; bus.iWE = 1'b0;
      check("wr_ack", 32'(bus.oACK), 32'h1);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] r);
      @(posedge clk); #2;
      bus.iADR = a; bus.iWE = 1'b0; bus.iSTB = 1'b1;
      @(posedge clk); #2;
      bus.iSTB = 1'b0;
      check("rd_ack", 32'(bus.oACK), 32'h1);
      r = bus.oDAT;
   endtask

   initial begin
      logic [31:0] r;
      int          hi_cnt;
      int          busy_cnt;

      bus.iADR = '0; bus.iDAT = '0; bus.iWE = 1'b0; bus.iSTB = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      check("reset_dout", 32'(dout), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_ack",  32'(bus.oACK), 32'h0);
      check("reset_dat",  bus.oDAT, 32'h0);

      wr(32'h00, 32'h12);
      wr(32'h10, 32'h34);
      wr(32'h20, 32'h56);
      check("data_pack", 32'(dout), 32'h563412);
      rd(32'h00, r); check("rd_ch0", r, 32'h12);
      rd(32'h10, r); check("rd_ch1", r, 32'h34);
      rd(32'h20, r); check("rd_ch2", r, 32'h56);
      @(posedge clk); #2;
      check("ack_one_cycle", 32'(bus.oACK), 32'h0);
      check("dat_idle_zero", bus.oDAT, 32'h0);

      wr(32'h00, 32'h0F);
      wr(32'h04, 32'hF0);
      check("set_ff", 32'(dout[7:0]), 32'hFF);
      wr(32'h08, 32'h3C);
      check("clr_c3", 32'(dout[7:0]), 32'hC3);
      rd(32'h00, r); check("rd_c3", r, 32'h000000C3);

      wr(32'h10, 32'h00);
      wr(32'h1C, 32'h0005_0081);
      hi_cnt = 0; busy_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (dout[15:8] == 8'h81) hi_cnt++;
         if (busy[1]) busy_cnt++;
      end
      check("pulse_len", 32'(hi_cnt), 32'd5);
      check("pulse_busy_len", 32'(busy_cnt), 32'd5);
      check("pulse_restored", 32'(dout[15:8]), 32'h0);
      wr(32'h1C, 32'h0005_0081);
      rd(32'h1C, r); check("pulse_rd", r, 32'h0004_0081);
      repeat (8) @(posedge clk);

      wr(32'h2C, 32'h000A_0001);
      check("retrig_first", 32'(dout[23:16]), 32'h57);
      repeat (2) @(posedge clk);
      wr(32'h2C, 32'h0004_0002);
      check("retrig_swap", 32'(dout[23:16]), 32'h54);
      repeat (3) @(posedge clk); #2;
      check("retrig_hold", 32'(dout[23:16]), 32'h54);
      check("retrig_busy", 32'(busy[2]), 32'h1);
      @(posedge clk); #2;
      check("retrig_end", 32'(dout[23:16]), 32'h56);
      check("retrig_idle", 32'(busy[2]), 32'h0);

      wr(32'h2C, 32'h0003_00FF);
      check("exp_pulse", 32'(dout[23:16]), 32'hA9);
      @(posedge clk);
      wr(32'h20, 32'h99);
      check("exp_write", 32'(dout[23:16]), 32'h99);
      check("exp_busy", 32'(busy[2]), 32'h0);
      repeat (3) @(posedge clk); #2;
      check("exp_no_restore", 32'(dout[23:16]), 32'h99);

      wr(32'h30, 32'hAA);
      check("oor_dout", 32'(dout), 32'h9900C3);
      rd(32'h30, r); check("oor_rd", r, 32'h0);
      rd(32'h3C, r); check("oor_rd_pulse", r, 32'h0);

      wr(32'h0C, 32'h0064_0001);
      check("rst_pulse_on", 32'(dout), 32'h9900C2);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check("rst_mid_dout", 32'(dout), 32'h0);
      check("rst_mid_busy", 32'(busy), 32'h0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (3) @(posedge clk); #2;
      check("rst_no_restore", 32'(dout), 32'h0);

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         if ($urandom_range(0, 499) == 0) begin
            bus.iSTB = 1'b0;
            rst = 1'b1;
            @(posedge clk); #2;
            rst = 1'b0;
         end
         bus.iSTB = ($urandom_range(0, 9) < 6);
         bus.iWE  = ($urandom_range(0, 2) != 0);
         bus.iADR = {24'($urandom), 4'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
         bus.iDAT = {16'($urandom_range(0, 12)), 16'($urandom)};
      end
      @(posedge clk); #2;
      bus.iSTB = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
